// File: rtl/conv_core.sv
`default_nettype none
// ============================================================================
//  Module   : conv_core
//  Purpose  : KSIZE x KSIZE convolution core. One window per cycle is
//             multiplied by a serially loaded weight register, reduced by a
//             registered adder tree, scaled by FRAC and saturated. Results are
//             accumulated over input channels in an internal buffer. The pixel
//             is emitted on the last channel, with optional ReLU.
//  Ports    : clk, xrst (async, active low)
//             wreg_we/read_weight     - shift one weight into the register
//             in_valid/pixel_in       - window (element 0 = top-left)
//             first_ch/last_ch        - channel position (overwrite / emit)
//             acc_addr/relu_en        - buffer address, output ReLU enable
//             out_valid/out_addr/pixel_out - emitted result, LAT = clog2(K2)+3
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module conv_core #(
    parameter int DWIDTH = 16,
    parameter int KSIZE  = 3,
    parameter int FRAC   = 8,
    parameter int ADDR   = 10
) (
    input  logic                            clk,
    input  logic                            xrst,
    input  logic                            wreg_we,
    input  logic [DWIDTH-1:0]               read_weight,
    input  logic                            in_valid,
    input  logic [DWIDTH*KSIZE*KSIZE-1:0]   pixel_in,
    input  logic                            first_ch,
    input  logic                            last_ch,
    input  logic [ADDR-1:0]                 acc_addr,
    input  logic                            relu_en,
    output logic                            out_valid,
    output logic [ADDR-1:0]                 out_addr,
    output logic [DWIDTH-1:0]               pixel_out
);

    localparam int K2    = KSIZE * KSIZE;
    localparam int D     = (K2 > 1) ? $clog2(K2) : 0;
    localparam int SW    = 2 * DWIDTH + D;   // tree width, cannot overflow
    localparam int MW    = ADDR + 4;         // {valid, first, last, relu, addr}
    localparam int DEPTH = 1 << ADDR;

    localparam logic signed [SW-1:0] c_sum_max =
        {{(SW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] c_sum_min =
        {{(SW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] c_out_max = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] c_out_min = {1'b1, {(DWIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Weight shift register: newest weight enters at the top, so the
    // first of K2 writes ends up in w[0].
    // ------------------------------------------------------------------
    logic signed [DWIDTH-1:0] r_w [0:K2-1];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < K2; i++) r_w[i] <= '0;
        end else if (wreg_we) begin
            for (int i = 0; i < K2 - 1; i++) r_w[i] <= r_w[i+1];
            r_w[K2-1] <= read_weight;
        end
    end

    // ------------------------------------------------------------------
    // Multiply (level 0) and adder tree (levels 1..D). Level lv holds
    // ceil(K2 / 2**lv) live nodes; the remaining slots are tied to zero.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] r_tree     [0:D][0:K2-1];
    logic signed [SW-1:0] w_tree_nxt [0:D][0:K2-1];

    generate
        for (genvar j = 0; j < K2; j++) begin : g_mul
            logic signed [2*DWIDTH-1:0] w_prod;
            assign w_prod = $signed(pixel_in[j*DWIDTH +: DWIDTH]) * r_w[j];
            assign w_tree_nxt[0][j] = SW'(w_prod);
        end

        for (genvar lv = 1; lv <= D; lv++) begin : g_lvl
            localparam int N_PREV = (K2 + (1 << (lv-1)) - 1) >> (lv-1);
            for (genvar j = 0; j < K2; j++) begin : g_node
                if (2*j + 1 < N_PREV) begin : g_add
                    assign w_tree_nxt[lv][j] = r_tree[lv-1][2*j] + r_tree[lv-1][2*j+1];
                end else if (2*j < N_PREV) begin : g_pass
                    assign w_tree_nxt[lv][j] = r_tree[lv-1][2*j];
                end else begin : g_zero
                    assign w_tree_nxt[lv][j] = '0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Side-band pipeline travelling alongside the data.
    // r_meta[k] belongs to stage S(k+1).
    // ------------------------------------------------------------------
    logic [MW-1:0] r_meta [0:D+1];
    logic [MW-1:0] w_meta_in;

    assign w_meta_in = {in_valid, first_ch, last_ch, relu_en, acc_addr};

    // ------------------------------------------------------------------
    // Scale / saturate stage.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] w_shift;
    logic [DWIDTH-1:0]    w_scaled;

    assign w_shift  = r_tree[D][0] >>> FRAC;
    assign w_scaled = (w_shift > c_sum_max) ? c_out_max :
                      (w_shift < c_sum_min) ? c_out_min :
                      w_shift[DWIDTH-1:0];

    // ------------------------------------------------------------------
    // Accumulate stage. The buffer is read one stage early (registered
    // read); if the window currently accumulating writes the same address
    // at that edge, its result is forwarded instead of the stale word.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] r_buf [0:DEPTH-1];
    logic [DWIDTH-1:0] r_scaled;
    logic [DWIDTH-1:0] r_rd;

    logic              w_acc_vld;
    logic              w_acc_first;
    logic              w_acc_last;
    logic              w_acc_relu;
    logic [ADDR-1:0]   w_acc_addr;
    logic [ADDR-1:0]   w_rd_addr;
    logic signed [DWIDTH:0] w_sum_ext;
    logic [DWIDTH-1:0] w_sum_sat;
    logic [DWIDTH-1:0] w_acc;

    assign {w_acc_vld, w_acc_first, w_acc_last, w_acc_relu, w_acc_addr} = r_meta[D+1];
    assign w_rd_addr = r_meta[D][ADDR-1:0];

    assign w_sum_ext = $signed({r_rd[DWIDTH-1], r_rd}) +
                       $signed({r_scaled[DWIDTH-1], r_scaled});
    assign w_sum_sat = (w_sum_ext[DWIDTH] != w_sum_ext[DWIDTH-1])
                     ? (w_sum_ext[DWIDTH] ? c_out_min : c_out_max)
                     : w_sum_ext[DWIDTH-1:0];
    assign w_acc     = w_acc_first ? r_scaled : w_sum_sat;

    // ------------------------------------------------------------------
    // Pipeline registers.
    // ------------------------------------------------------------------
    logic              r_out_valid;
    logic [ADDR-1:0]   r_out_addr;
    logic [DWIDTH-1:0] r_pixel_out;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int lv = 0; lv <= D; lv++)
                for (int j = 0; j < K2; j++)
                    r_tree[lv][j] <= '0;
            for (int k = 0; k <= D + 1; k++) r_meta[k] <= '0;
            r_scaled    <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_pixel_out <= '0;
        end else begin
            for (int lv = 0; lv <= D; lv++)
                for (int j = 0; j < K2; j++)
                    r_tree[lv][j] <= w_tree_nxt[lv][j];
            r_meta[0] <= w_meta_in;
            for (int k = 1; k <= D + 1; k++) r_meta[k] <= r_meta[k-1];

            r_scaled <= w_scaled;
            r_rd     <= (w_acc_vld && (w_acc_addr == w_rd_addr)) ? w_acc : r_buf[w_rd_addr];

            if (w_acc_vld && w_acc_last) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= w_acc_addr;
                r_pixel_out <= (w_acc_relu && w_acc[DWIDTH-1]) ? '0 : w_acc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Buffer keeps its contents over reset; first_ch always overwrites.
    // The stored value is the pre-ReLU accumulation.
    always_ff @(posedge clk) begin
        if (w_acc_vld) r_buf[w_acc_addr] <= w_acc;
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign pixel_out = r_pixel_out;

endmodule
`default_nettype wire

// File: tb/tb_conv_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_core
//  Purpose  : Directed self-checking bench for conv_core (16-bit, 3x3, FRAC 8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_core;

    localparam int DW  = 16;
    localparam int K2  = 9;
    localparam int AW  = 10;
    localparam int LAT = 7;

    logic              clk = 1'b0;
    logic              xrst;
    logic              wreg_we;
    logic [DW-1:0]     read_weight;
    logic              in_valid;
    logic [DW*K2-1:0]  pixel_in;
    logic              first_ch;
    logic              last_ch;
    logic [AW-1:0]     acc_addr;
    logic              relu_en;
    logic              out_valid;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     pixel_out;

    always #5 clk = ~clk;

    conv_core #(
        .DWIDTH (DW),
        .KSIZE  (3),
        .FRAC   (8),
        .ADDR   (AW)
    ) dut (
        .clk         (clk),
        .xrst        (xrst),
        .wreg_we     (wreg_we),
        .read_weight (read_weight),
        .in_valid    (in_valid),
        .pixel_in    (pixel_in),
        .first_ch    (first_ch),
        .last_ch     (last_ch),
        .acc_addr    (acc_addr),
        .relu_en     (relu_en),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .pixel_out   (pixel_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int q_pix  [$];
    int q_addr [$];
    int q_cyc  [$];
    int q_sent [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            q_pix.push_back($signed(pixel_out));
            q_addr.push_back(int'(out_addr));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW*K2-1:0] win_seq();
        logic [DW*K2-1:0] w;
        for (int i = 0; i < K2; i++) w[i*DW +: DW] = DW'(i + 1);
        return w;
    endfunction

    function automatic logic [DW*K2-1:0] win_const(input int v);
        logic [DW*K2-1:0] w;
        for (int i = 0; i < K2; i++) w[i*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic logic [DW*K2-1:0] win_one(input int v);
        logic [DW*K2-1:0] w;
        w = '0;
        w[DW-1:0] = DW'(v);
        return w;
    endfunction

    task automatic load_w(input int v);
        for (int i = 0; i < K2; i++) begin
            wreg_we     = 1'b1;
            read_weight = DW'(v);
            @(negedge clk);
        end
        wreg_we = 1'b0;
    endtask

    task automatic send(input logic [DW*K2-1:0] win, input logic f, input logic l,
                        input int addr, input logic relu);
        in_valid = 1'b1;
        pixel_in = win;
        first_ch = f;
        last_ch  = l;
        acc_addr = AW'(addr);
        relu_en  = relu;
        if (l) q_sent.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
        wreg_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input int pix, input int addr);
        check({tag, "_present"}, int'(q_pix.size() > 0), 1);
        if (q_pix.size() > 0) begin
            int p, a, c, s;
            p = q_pix.pop_front();
            a = q_addr.pop_front();
            c = q_cyc.pop_front();
            s = (q_sent.size() > 0) ? q_sent.pop_front() : -100;
            check({tag, "_pix"}, p, pix);
            check({tag, "_addr"}, a, addr);
            check({tag, "_lat"}, c - s, LAT);
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_extra"}, q_pix.size(), 0);
        q_pix.delete();
        q_addr.delete();
        q_cyc.delete();
    endtask

    initial begin
        xrst        = 1'b0;
        wreg_we     = 1'b0;
        read_weight = '0;
        in_valid    = 1'b0;
        pixel_in    = '0;
        first_ch    = 1'b0;
        last_ch     = 1'b0;
        acc_addr    = '0;
        relu_en     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_addr",  int'(out_addr), 0);
        check("rst_pix",   $signed(pixel_out), 0);
        xrst = 1'b1;
        @(negedge clk);

        // Basic single-channel window with unity weights.
        load_w(256);
        send(win_seq(), 1'b1, 1'b1, 5, 1'b0);
        idle(LAT + 2);
        expect_out("t1", 45, 5);
        check("t1_hold_valid", int'(out_valid), 0);
        check("t1_hold_pix", $signed(pixel_out), 45);
        check("t1_hold_addr", int'(out_addr), 5);

        // Stale 1000 in addr 5, then three spaced channels.
        send(win_one(1000), 1'b1, 1'b1, 5, 1'b0);
        idle(LAT + 2);
        expect_out("t2_stale", 1000, 5);
        send(win_seq(), 1'b1, 1'b0, 5, 1'b0);
        idle(1);
        send(win_seq(), 1'b0, 1'b0, 5, 1'b0);
        idle(1);
        send(win_seq(), 1'b0, 1'b1, 5, 1'b0);
        idle(LAT + 2);
        expect_out("t2_3ch", 135, 5);
        expect_none("t2");

        // Back-to-back same address, then interleaved addresses.
        send(win_seq(), 1'b1, 1'b0, 7, 1'b0);
        send(win_seq(), 1'b0, 1'b1, 7, 1'b0);
        idle(LAT + 2);
        expect_out("t3_fwd", 90, 7);
        send(win_seq(), 1'b1, 1'b0, 8, 1'b0);
        send(win_seq(), 1'b1, 1'b0, 9, 1'b0);
        send(win_seq(), 1'b0, 1'b1, 8, 1'b0);
        send(win_seq(), 1'b0, 1'b1, 9, 1'b0);
        idle(LAT + 2);
        expect_out("t3_a8", 90, 8);
        expect_out("t3_a9", 90, 9);
        expect_none("t3");

        // Saturation, sign and ReLU.
        load_w(32767);
        send(win_const(32767), 1'b1, 1'b1, 1, 1'b0);
        load_w(-32768);
        send(win_const(32767), 1'b1, 1'b1, 2, 1'b0);
        idle(LAT + 2);
        expect_out("t4_satp", 32767, 1);
        expect_out("t4_satn", -32768, 2);
        load_w(-256);
        send(win_seq(), 1'b1, 1'b1, 3, 1'b0);
        send(win_seq(), 1'b1, 1'b1, 3, 1'b1);
        send(win_seq(), 1'b0, 1'b1, 3, 1'b0);
        idle(LAT + 2);
        expect_out("t4_neg", -45, 3);
        expect_out("t4_relu", 0, 3);
        expect_out("t4_prerelu", -90, 3);
        load_w(256);
        send(win_one(30000), 1'b1, 1'b0, 4, 1'b0);
        send(win_one(30000), 1'b0, 1'b1, 4, 1'b1);
        load_w(-256);
        send(win_one(30000), 1'b1, 1'b0, 6, 1'b0);
        send(win_one(30000), 1'b0, 1'b1, 6, 1'b0);
        idle(LAT + 2);
        expect_out("t4_accp", 32767, 4);
        expect_out("t4_accn", -32768, 6);
        load_w(-1);
        send(win_seq(), 1'b1, 1'b1, 15, 1'b0);
        load_w(1);
        send(win_seq(), 1'b1, 1'b1, 16, 1'b0);
        idle(LAT + 2);
        expect_out("t4_floor", -1, 15);
        expect_out("t4_trunc", 0, 16);
        expect_none("t4");

        // Weight write in the same cycle as a window.
        load_w(256);
        wreg_we     = 1'b1;
        read_weight = DW'(512);
        send(win_seq(), 1'b1, 1'b1, 10, 1'b0);
        send(win_seq(), 1'b1, 1'b1, 11, 1'b0);
        idle(LAT + 2);
        expect_out("t5_old", 45, 10);
        expect_out("t5_new", 54, 11);
        expect_none("t5");

        // Reset in the middle of a window's flight.
        load_w(256);
        send(win_seq(), 1'b1, 1'b1, 12, 1'b0);
        idle(2);
        xrst = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_addr",  int'(out_addr), 0);
        check("t6_rst_pix",   $signed(pixel_out), 0);
        idle(2);
        xrst = 1'b1;
        q_sent.delete();
        idle(LAT + 3);
        expect_none("t6_drop");
        send(win_seq(), 1'b1, 1'b1, 14, 1'b0);
        idle(LAT + 2);
        expect_out("t6_w0", 0, 14);
        load_w(256);
        send(win_seq(), 1'b1, 1'b1, 13, 1'b0);
        idle(LAT + 2);
        expect_out("t6_after", 45, 13);
        expect_none("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
